time_load_ctrl: RTL and testbench
=================================

# time_load_ctrl

Sequencer for the clock's BCD digit chain. Generates the once-per-second increment pulse that drives the seconds-units digit. Latches decoded MSF time frames and applies them to all digits with a single-cycle broadcast load at the next minute marker. Sits between the MSF frame decoder and the chained digit counters, which provide inc/ovf/load/load_value ports.

## Interface
- CLK_HZ, 10000: system clock frequency in Hz; prescaler period in cycles.
- ARM_TIMEOUT_S, 62: seconds an armed frame may wait for a minute marker before it is discarded.
- clk_i  in  1  system clock, single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- frame_valid_i  in  1  one-cycle pulse; decoded frame fields valid this cycle.
- min_units_i  in  4  BCD minute units.
- min_tens_i  in  3  BCD minute tens.
- hour_units_i  in  4  BCD hour units.
- hour_tens_i  in  2  BCD hour tens.
- minute_mark_i  in  1  one-cycle pulse at the start of second 00 of a new minute.
- inc_o  out  1  one-cycle seconds increment to the seconds-units digit.
- load_o  out  1  one-cycle broadcast load to all six digits. Seconds digits load 0.
- min_units_o, min_tens_o, hour_units_o, hour_tens_o  out  4/3/4/2  load values, stable while load_o is high.
- synced_o  out  1  high once at least one frame has been loaded.
- err_o  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Prescaler: counter cnt in 0..CLK_HZ-1, width $clog2(CLK_HZ).
  - Increments every cycle and wraps to 0 after CLK_HZ-1.
  - inc_o = (cnt == CLK_HZ-1) and not loading this cycle.
- FSM states are IDLE, ARMED and LOAD.
- IDLE:
  - An accepted frame_valid_i latches all four fields into frame registers and moves to ARMED.
  - A minute_mark_i received in IDLE is ignored.
- ARMED:
  - A new accepted frame_valid_i overwrites the frame registers and restarts the timeout.
  - minute_mark_i moves to LOAD.
  - The timeout counter counts prescaler wraps. When it reaches ARM_TIMEOUT_S, the frame is discarded and the FSM returns to IDLE.
- LOAD (exactly one cycle):
  - load_o = 1, driving the output values from the frame registers.
  - cnt is forced to 0 and inc_o is suppressed.
  - synced_o is set.
  - The next state is IDLE.
- Frame acceptance, when the range check is compiled in (see Configuration):
  - min_tens ≤ 5 and min_units ≤ 9.
  - hour_tens ≤ 2 and hour_units ≤ 9.
  - If hour_tens == 2, hour_units ≤ 3.
  - A rejected frame pulses err_o, leaves the state and frame registers unchanged, and does not restart the timeout.
- Simultaneous events:
  - frame_valid_i and minute_mark_i in the same cycle while ARMED: the existing frame loads (to LOAD). The new frame is dropped and err_o is not pulsed.
  - frame_valid_i and minute_mark_i in the same cycle while IDLE: the frame is latched and the FSM goes to ARMED. It loads at the next marker.
  - Timeout expiry and minute_mark_i in the same cycle: the marker wins and the FSM goes to LOAD.
- Load values are held at their last loaded values between loads; they are only meaningful while load_o = 1.

## Timing
- Reset values (asynchronous assertion, synchronous-safe deassertion):
  - FSM = IDLE, cnt = 0, timeout = 0, frame registers = 0.
  - inc_o = 0, load_o = 0, err_o = 0, synced_o = 0.
  - All value outputs = 0.
- inc_o: first pulse in the CLK_HZ-th cycle after reset release, then every CLK_HZ cycles.
- minute_mark_i → load_o: latency 1 cycle. The registered load_o is high in the cycle after the marker.
- The first inc_o after a load occurs CLK_HZ cycles after the load_o cycle.
- err_o: latency 1 cycle from the rejected frame_valid_i.
- All outputs are registered.
- Reset asserted mid-LOAD: load_o drops immediately (asynchronously) and synced_o clears.

## Configuration
- TIME_LOAD_CTRL_BCD_CHECK_EN defined:
  - The range check applies.
  - Invalid frames are rejected and pulse err_o.
- Not defined:
  - Every frame_valid_i is accepted.
  - err_o is tied to 0.
  - The comparison logic is removed.

## Test plan
- Reset release, CLK_HZ=10 → inc_o pulses at cycles 10, 20, 30. load_o, synced_o and err_o stay 0.
- Frame 12:34 (hour_tens=1, hour_units=2, min_tens=3, min_units=4), then minute_mark_i 5 cycles later → load_o high for 1 cycle the next cycle with values 1/2/3/4. synced_o = 1. Next inc_o occurs 10 cycles after load_o.
- With TIME_LOAD_CTRL_BCD_CHECK_EN, frame hour 24 → err_o pulse 1 cycle later. FSM stays IDLE, so a following marker produces no load_o.
- Frame 07:59 armed, then no marker for ARM_TIMEOUT_S=3 inc pulses → FSM returns to IDLE. A later marker produces no load_o.
- Frame 01:00 armed, then frame 01:01 and minute_mark_i in the same cycle → load_o with 01:00. FSM returns to IDLE and 01:01 is not latched.
- rst_ni pulsed low during the LOAD cycle → load_o and synced_o read 0 immediately. inc_o restarts at cycle CLK_HZ after release.

Source files
------------

// File: rtl/time_load_ctrl.sv
// Seconds prescaler and MSF frame load sequencer for the BCD digits.
// Ports: clk_i/rst_ni, frame_valid_i + BCD fields, minute_mark_i,
//   inc_o, load_o, load values, synced_o, err_o.
// Optional: TIME_LOAD_CTRL_BCD_CHECK_EN enables frame range checking.
module time_load_ctrl #(
  parameter int CLK_HZ        = 10000,
  parameter int ARM_TIMEOUT_S = 62
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_valid_i,
  input  logic [3:0] min_units_i,
  input  logic [2:0] min_tens_i,
  input  logic [3:0] hour_units_i,
  input  logic [1:0] hour_tens_i,
  input  logic       minute_mark_i,
  output logic       inc_o,
  output logic       load_o,
  output logic [3:0] min_units_o,
  output logic [2:0] min_tens_o,
  output logic [3:0] hour_units_o,
  output logic [1:0] hour_tens_o,
  output logic       synced_o,
  output logic       err_o
);

  localparam int CW = $clog2(CLK_HZ);
  localparam int TW = $clog2(ARM_TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOAD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      f_mu_q, f_hu_q;
  logic [2:0]      f_mt_q;
  logic [1:0]      f_ht_q;
  logic            inc_q, err_q, synced_q;
  logic            wrap, frame_ok;
  logic            latch, go_load, err_d;

  assign wrap = (cnt_q == CW'(CLK_HZ - 1));

`ifdef TIME_LOAD_CTRL_BCD_CHECK_EN
  assign frame_ok = (min_tens_i <= 3'd5)
                 && (min_units_i <= 4'd9)
                 && (hour_tens_i <= 2'd2)
                 && (hour_units_i <= 4'd9)
                 && !((hour_tens_i == 2'd2)
                      && (hour_units_i > 4'd3));
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    latch   = 1'b0;
    go_load = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_valid_i) begin
          if (frame_ok) begin
            latch   = 1'b1;
            tmo_d   = '0;
            state_d = ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARMED: begin
        // Marker wins over a new frame and over expiry.
        if (minute_mark_i) begin
          go_load = 1'b1;
          tmo_d   = '0;
          state_d = LOAD;
        end else if (frame_valid_i && frame_ok) begin
          latch = 1'b1;
          tmo_d = '0;
        end else begin
          err_d = frame_valid_i;
          if (wrap) begin
            if (tmo_q == TW'(ARM_TIMEOUT_S - 1)) begin
              tmo_d   = '0;
              state_d = IDLE;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Clearing cnt on entry to LOAD realigns the second to the marker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      inc_q <= 1'b0;
    end else begin
      cnt_q <= (go_load || wrap) ? '0 : cnt_q + CW'(1);
      inc_q <= wrap && !go_load;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_mu_q <= '0;
      f_mt_q <= '0;
      f_hu_q <= '0;
      f_ht_q <= '0;
    end else if (latch) begin
      f_mu_q <= min_units_i;
      f_mt_q <= min_tens_i;
      f_hu_q <= hour_units_i;
      f_ht_q <= hour_tens_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_units_o  <= '0;
      min_tens_o   <= '0;
      hour_units_o <= '0;
      hour_tens_o  <= '0;
      synced_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (go_load) begin
        min_units_o  <= f_mu_q;
        min_tens_o   <= f_mt_q;
        hour_units_o <= f_hu_q;
        hour_tens_o  <= f_ht_q;
      end
      synced_q <= synced_q | go_load;
      err_q    <= err_d;
    end
  end

  assign inc_o    = inc_q;
  assign load_o   = (state_q == LOAD);
  assign synced_o = synced_q;
`ifdef TIME_LOAD_CTRL_BCD_CHECK_EN
  assign err_o    = err_q;
`else
  assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_time_load_ctrl.sv
// Directed bench for time_load_ctrl (CLK_HZ=10, ARM_TIMEOUT_S=3).
// Cycle n means the interval just after the n-th edge after reset.
module tb_time_load_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       frame_valid_i = 1'b0;
  logic [3:0] min_units_i = '0;
  logic [2:0] min_tens_i = '0;
  logic [3:0] hour_units_i = '0;
  logic [1:0] hour_tens_i = '0;
  logic       minute_mark_i = 1'b0;
  logic       inc_o, load_o, synced_o, err_o;
  logic [3:0] min_units_o, hour_units_o;
  logic [2:0] min_tens_o;
  logic [1:0] hour_tens_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  time_load_ctrl #(
    .CLK_HZ(10),
    .ARM_TIMEOUT_S(3)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .frame_valid_i(frame_valid_i),
    .min_units_i(min_units_i),
    .min_tens_i(min_tens_i),
    .hour_units_i(hour_units_i),
    .hour_tens_i(hour_tens_i),
    .minute_mark_i(minute_mark_i),
    .inc_o(inc_o),
    .load_o(load_o),
    .min_units_o(min_units_o),
    .min_tens_o(min_tens_o),
    .hour_units_o(hour_units_o),
    .hour_tens_o(hour_tens_o),
    .synced_o(synced_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    frame_valid_i = 1'b0;
    minute_mark_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    cyc = 0;
  endtask

  // Frame presented for the next edge only.
  task automatic frame(input logic [1:0] ht, input logic [3:0] hu,
                       input logic [2:0] mt, input logic [3:0] mu,
                       input logic mark);
    frame_valid_i = 1'b1;
    hour_tens_i = ht;
    hour_units_i = hu;
    min_tens_i = mt;
    min_units_i = mu;
    minute_mark_i = mark;
    tick();
    frame_valid_i = 1'b0;
    minute_mark_i = 1'b0;
  endtask

  task automatic mark();
    minute_mark_i = 1'b1;
    tick();
    minute_mark_i = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst_ni = 1'b0;
    tick();
    got = {inc_o, load_o, synced_o, err_o, hour_tens_o,
           hour_units_o, min_tens_o, min_units_o};
    checks++;
    if (got !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    rst_ni = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if (inc_o !== (k % 10 == 0)) begin
        failures++;
        $display("FAIL reset_inc cyc=%0d got=%b exp=%b",
                 k, inc_o, (k % 10 == 0));
      end
      checks++;
      if ({load_o, synced_o, err_o} !== 3'b000) begin
        failures++;
        $display("FAIL reset_quiet cyc=%0d got=%b exp=000",
                 k, {load_o, synced_o, err_o});
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    frame(2'd1, 4'd2, 3'd3, 4'd4, 1'b0);
    run_to(5);
    mark();
    checks++;
    if ({load_o, synced_o} !== 2'b11) begin
      failures++;
      $display("FAIL load_pulse got=%b exp=11", {load_o, synced_o});
    end
    checks++;
    if ({hour_tens_o, hour_units_o, min_tens_o, min_units_o}
        !== {2'd1, 4'd2, 3'd3, 4'd4}) begin
      failures++;
      $display("FAIL load_value got=%h%h:%h%h exp=12:34",
               hour_tens_o, hour_units_o, min_tens_o, min_units_o);
    end
    for (int k = 7; k <= 16; k++) begin
      tick();
      checks++;
      if ({inc_o, load_o} !== {k == 16, 1'b0}) begin
        failures++;
        $display("FAIL load_inc cyc=%0d got=%b exp=%b",
                 k, {inc_o, load_o}, {k == 16, 1'b0});
      end
    end
    checks++;
    if ({synced_o, min_units_o} !== {1'b1, 4'd4}) begin
      failures++;
      $display("FAIL load_hold got=%b/%h exp=1/4",
               synced_o, min_units_o);
    end
  endtask

  task automatic test_bad_frame();
    do_reset();
    frame(2'd2, 4'd4, 3'd0, 4'd0, 1'b0);
`ifdef TIME_LOAD_CTRL_BCD_CHECK_EN
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL bad_err got=%b exp=1", err_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL bad_err_len got=%b exp=0", err_o);
    end
    mark();
    checks++;
    if (load_o !== 1'b0) begin
      failures++;
      $display("FAIL bad_noload got=%b exp=0", load_o);
    end
`else
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL bad_err got=%b exp=0", err_o);
    end
    tick();
    mark();
    checks++;
    if ({load_o, hour_tens_o, hour_units_o} !== {1'b1, 2'd2, 4'd4}) begin
      failures++;
      $display("FAIL bad_accept got=%b/%h%h exp=1/24",
               load_o, hour_tens_o, hour_units_o);
    end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    frame(2'd0, 4'd7, 3'd5, 4'd9, 1'b0);
    run_to(25);
    mark();
    checks++;
    if (load_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_2s got=%b exp=1", load_o);
    end
    do_reset();
    frame(2'd0, 4'd7, 3'd5, 4'd9, 1'b0);
    run_to(29);
    mark();
    checks++;
    if ({load_o, inc_o} !== 2'b10) begin
      failures++;
      $display("FAIL tmo_tie got=%b exp=10", {load_o, inc_o});
    end
    do_reset();
    frame(2'd0, 4'd7, 3'd5, 4'd9, 1'b0);
    run_to(30);
    checks++;
    if (inc_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_inc3 got=%b exp=1", inc_o);
    end
    mark();
    checks++;
    if (load_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_expired got=%b exp=0", load_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame(2'd0, 4'd1, 3'd0, 4'd0, 1'b0);
    tick();
    frame(2'd0, 4'd1, 3'd0, 4'd1, 1'b1);
    checks++;
    if ({load_o, err_o, hour_units_o, min_units_o}
        !== {2'b10, 4'd1, 4'd0}) begin
      failures++;
      $display("FAIL simul_armed got=%b%b/%h/%h exp=10/1/0",
               load_o, err_o, hour_units_o, min_units_o);
    end
    tick();
    mark();
    checks++;
    if (load_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_dropped got=%b exp=0", load_o);
    end
    frame(2'd0, 4'd5, 3'd0, 4'd6, 1'b1);
    checks++;
    if (load_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle got=%b exp=0", load_o);
    end
    tick();
    mark();
    checks++;
    if ({load_o, hour_units_o, min_units_o}
        !== {1'b1, 4'd5, 4'd6}) begin
      failures++;
      $display("FAIL simul_idle_load got=%b/%h/%h exp=1/5/6",
               load_o, hour_units_o, min_units_o);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    frame(2'd1, 4'd2, 3'd3, 4'd4, 1'b0);
    tick();
    mark();
    checks++;
    if (load_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%b exp=1", load_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({load_o, synced_o} !== 2'b00) begin
      failures++;
      $display("FAIL mid_async got=%b exp=00", {load_o, synced_o});
    end
    tick();
    rst_ni = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (inc_o !== (k == 10)) begin
        failures++;
        $display("FAIL mid_inc cyc=%0d got=%b exp=%b",
                 k, inc_o, (k == 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_frame();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
